ps2_rx_frame: RTL and testbench

- Second-generation PS/2 keyboard receiver; runs entirely in the system clock domain.
- Oversamples the keyboard's ps2_clk and ps2_data lines and rebuilds 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Checks framing and parity, then folds the 0xE0/0xF0 prefix bytes into the key event that follows.
- Buffers decoded key events in a FIFO with a valid/ready handshake toward the key-matrix/host logic.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_event_fifo.sv | 69 ++++++
 rtl/ps2_rx_frame.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state and key-event payload for the PS/2 frame receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BAT  = 8'hAA;
    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_REL  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    localparam int unsigned PS2_EVENT_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       is_release;
        logic       is_extended;
        logic       reset_req;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous key-event FIFO; head, valid, full, empty and level are all registered.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  ps2_event_t               din,
    input  logic                     pop,
    output ps2_event_t               dout,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    ps2_event_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [LW-1:0] level_next;
    logic          wr_en;
    logic          rd_en;
    ps2_event_t    head_next;

    assign rd_en      = pop && valid;
    assign wr_en      = push && (!full || rd_en);
    assign rd_next    = rd_en ? rd_ptr + PW'(1) : rd_ptr;
    assign level_next = level + LW'(wr_en) - LW'(rd_en);

    // The slot being written this cycle becomes the head when the FIFO was empty or drains to it.
    always_comb begin
        head_next = '0;
        if (level_next != '0) begin
            if (wr_en && (wr_ptr == rd_next)) head_next = din;
            else                              head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_next;
            level  <= level_next;
            dout   <= head_next;
            valid  <= (level_next != '0);
            full   <= (level_next == LW'(DEPTH));
            empty  <= (level_next == '0);
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame FSM, prefix folding, event FIFO.
// Define PS2_RX_TIMEOUT_EN to abort frames whose ps2_clk edges stop arriving.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_release,
    output logic                          evt_extended,
    output logic                          evt_reset_req,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
    logic [1:0]    sync_q [SYNC_STAGES];
    logic [1:0]    filt_q;
    logic [1:0]    filt_prev_q;
    logic [FW-1:0] filt_cnt_q [2];
    logic          fall;
    logic          bit_in;

    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          byte_ok_q;
    logic          ext_q;
    logic          rel_q;

    logic          push_c;
    ps2_event_t    push_evt;
    ps2_event_t    head;
    logic          fifo_full;
    logic          fifo_empty_unused;
    logic          pop;
    logic          timeout_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b11;
            filt_q        <= 2'b11;
            filt_prev_q   <= 2'b11;
            filt_cnt_q[0] <= '0;
            filt_cnt_q[1] <= '0;
        end else begin
            sync_q[0] <= {ps2_data, ps2_clk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            filt_prev_q <= filt_q;
            for (int l = 0; l < 2; l++) begin
                if (sync_q[SYNC_STAGES-1][l] == filt_q[l]) begin
                    filt_cnt_q[l] <= '0;
                end else if (filt_cnt_q[l] == FW'(FILTER_LEN - 1)) begin
                    filt_q[l]     <= sync_q[SYNC_STAGES-1][l];
                    filt_cnt_q[l] <= '0;
                end else begin
                    filt_cnt_q[l] <= filt_cnt_q[l] + FW'(1);
                end
            end
        end
    end

    assign fall   = filt_prev_q[0] & ~filt_q[0];
    assign bit_in = filt_q[1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    assign timeout_c = (state != ST_IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        to_cnt_q <= '0;
        else if ((state == ST_IDLE) || fall || timeout_c) to_cnt_q <= '0;
        else                                            to_cnt_q <= to_cnt_q + TW'(1);
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT_CYCLES;
    assign timeout_c      = 1'b0;
`endif

    // Decode cycle: prefixes and keyboard error codes never reach the FIFO.
    always_comb begin
        push_c   = 1'b0;
        push_evt = '0;
        if (byte_ok_q && (shift_q != PS2_EXT) && (shift_q != PS2_REL) &&
            (shift_q != PS2_ERR0) && (shift_q != PS2_ERR1)) begin
            push_c               = 1'b1;
            push_evt.code        = shift_q;
            push_evt.is_release  = rel_q;
            push_evt.is_extended = ext_q;
            push_evt.reset_req   = (shift_q == PS2_BAT) && !rel_q && !ext_q;
        end
    end

    assign pop = evt_valid && evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            byte_ok_q    <= 1'b0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            byte_ok_q    <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_overflow <= push_c && fifo_full && !pop;

            if (byte_ok_q) begin
                case (shift_q)
                    PS2_EXT: ext_q <= 1'b1;
                    PS2_REL: rel_q <= 1'b1;
                    default: begin
                        ext_q <= 1'b0;
                        rel_q <= 1'b0;
                    end
                endcase
            end

            if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!bit_in) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q[bit_cnt] <= bit_in;
                        bit_cnt          <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_q <= bit_in;
                        state    <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!bit_in)                   err_frame  <= 1'b1;
                        if (!(^{shift_q, parity_q}))   err_parity <= 1'b1;
                        if (bit_in && (^{shift_q, parity_q})) begin
                            byte_ok_q <= 1'b1;
                        end else begin
                            ext_q <= 1'b0;
                            rel_q <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (timeout_c) begin
                state     <= ST_IDLE;
                err_frame <= 1'b1;
                ext_q     <= 1'b0;
                rel_q     <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (push_evt),
        .pop   (pop),
        .dout  (head),
        .valid (evt_valid),
        .full  (fifo_full),
        .empty (fifo_empty_unused),
        .level (fifo_level)
    );

    assign evt_code      = head.code;
    assign evt_release   = head.is_release;
    assign evt_extended  = head.is_extended;
    assign evt_reset_req = head.reset_req;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: bit-banged PS/2 frames, event log, error pulse counters.
module tb_ps2_rx_frame;

    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned FIFO_DEPTH     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 100000;
    localparam int          LATENCY        = SYNC_STAGES + FILTER_LEN + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_release;
    logic       evt_extended;
    logic       evt_reset_req;
    logic       err_parity;
    logic       err_frame;
    logic       err_overflow;
    logic [2:0] fifo_level;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          stop_fall_cyc = 0;
    logic [10:0] ev_mem [64];
    int          ev_cyc [64];
    int          ev_n = 0;
    int          n_par = 0;
    int          n_frm = 0;
    int          n_ovf = 0;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_release   (evt_release),
        .evt_extended  (evt_extended),
        .evt_reset_req (evt_reset_req),
        .err_parity    (err_parity),
        .err_frame     (err_frame),
        .err_overflow  (err_overflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every accepted event and count error-pulse cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && evt_ready && ev_n < 64) begin
                ev_mem[ev_n] = {evt_code, evt_release, evt_extended, evt_reset_req};
                ev_cyc[ev_n] = cyc;
                ev_n = ev_n + 1;
            end
            if (err_parity)   n_par = n_par + 1;
            if (err_frame)    n_frm = n_frm + 1;
            if (err_overflow) n_ovf = n_ovf + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(10);
        ps2_clk       = 1'b0;
        stop_fall_cyc = cyc;
        wait_clk(20);
        ps2_clk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    task automatic check_one_event(input string tag, input int base, input logic [10:0] exp);
        check({tag, "_count"}, 32'(ev_n - base), 32'd1);
        check({tag, "_event"}, 32'(ev_mem[base]), 32'(exp));
    endtask

    initial begin
        int base;
        int p0;
        int f0;
        int o0;

        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        evt_ready = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);

        check("reset_valid",   32'(evt_valid), 32'd0);
        check("reset_level",   32'(fifo_level), 32'd0);
        check("reset_fields",  32'({evt_code, evt_release, evt_extended, evt_reset_req}), 32'd0);
        check("reset_errs",    32'({err_parity, err_frame, err_overflow}), 32'd0);

        // Plain make code, latency from the stop-bit edge
        base = ev_n;
        send_frame(8'h1C, 1'b0, 1'b1);
        check_one_event("make_1c", base, {8'h1C, 3'b000});
        check("make_1c_latency", 32'(ev_cyc[base] - stop_fall_cyc), 32'(LATENCY));

        // Extended release folds both prefixes
        base = ev_n;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check_one_event("ext_rel_75", base, {8'h75, 3'b110});

        // Parity error: one pulse, nothing pushed, then recovery
        base = ev_n;
        p0   = n_par;
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_err_pulses", 32'(n_par - p0), 32'd1);
        check("par_err_nopush", 32'(ev_n - base), 32'd0);
        base = ev_n;
        send_frame(8'h1C, 1'b0, 1'b1);
        check_one_event("par_recover", base, {8'h1C, 3'b000});

        // BAT with and without a prefix
        base = ev_n;
        send_frame(8'hAA, 1'b1, 1'b1);
        check_one_event("bat", base, {8'hAA, 3'b001});
        base = ev_n;
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b1);
        check_one_event("rel_aa", base, {8'hAA, 3'b100});

        // Bad stop bit clears a pending prefix
        base = ev_n;
        f0   = n_frm;
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("stop_err_pulses", 32'(n_frm - f0), 32'd1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_one_event("stop_err_clear", base, {8'h1C, 3'b000});

        // Keyboard error code is dropped and clears the prefix
        base = ev_n;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_one_event("err_code_clear", base, {8'h1C, 3'b000});

        // Overflow: five events into a four-entry FIFO with no consumer
        evt_ready = 1'b0;
        base = ev_n;
        o0   = n_ovf;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("hold_valid", 32'(evt_valid), 32'd1);
        check("hold_code",  32'(evt_code), 32'h1C);
        for (int i = 0; i < 4; i++) send_frame(8'h1C, 1'b0, 1'b1);
        check("ovf_level",   32'(fifo_level), 32'd4);
        check("ovf_pulses",  32'(n_ovf - o0), 32'd1);
        check("ovf_nopop",   32'(ev_n - base), 32'd0);
        evt_ready = 1'b1;
        wait_clk(10);
        check("drain_count", 32'(ev_n - base), 32'd4);
        for (int i = 0; i < 4; i++) check("drain_event", 32'(ev_mem[base + i]), 32'({8'h1C, 3'b000}));
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_valid", 32'(evt_valid), 32'd0);
        check("drain_fields", 32'({evt_code, evt_release, evt_extended, evt_reset_req}), 32'd0);

`ifdef PS2_RX_TIMEOUT_EN
        // Abandoned frame times out, next frame decodes
        f0 = n_frm;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(TIMEOUT_CYCLES + 100);
        check("timeout_pulses", 32'(n_frm - f0), 32'd1);
        base = ev_n;
        send_frame(8'h1C, 1'b0, 1'b1);
        check_one_event("timeout_recover", base, {8'h1C, 3'b000});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
